// File: rtl/soc_mem_pkg.sv
// Shared constants for the memory responder: IO decode, register map,
// UART state encoding and status-word layout.
package soc_mem_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [2:0] REG_LEDS        = 3'd0;
  localparam logic [2:0] REG_UART_DATA   = 3'd1;
  localparam logic [2:0] REG_UART_STATUS = 3'd2;
  localparam logic [2:0] REG_CYCLES      = 3'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_CNT_LO = 4;

  function automatic logic [31:0] uart_status(input logic busy, input logic full,
                                              input logic [3:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY] = busy;
    s[STAT_FULL] = full;
    s[STAT_CNT_LO +: 4] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 transmitter; one DIV-cycle slot per bit and
// one IDLE cycle between frames.
module uart_tx_fifo
  import soc_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 434
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              push,
  input  logic [7:0]                        push_data,
  output logic                              tx,
  output logic                              busy,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DIV);
  localparam logic [BW-1:0] RELOAD = BW'(DIV - 1);

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  uart_state_e   state;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;
  logic          pop, push_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = (state == IDLE) && (count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign busy    = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      tx     <= 1'b1;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= fifo[rd_ptr];
            state <= START;
            tx    <= 1'b0;
            baud  <= RELOAD;
          end
        end
        START: begin
          if (baud == '0) begin
            state  <= DATA;
            tx     <= shift[0];
            baud   <= RELOAD;
            bitcnt <= '0;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= RELOAD;
            if (bitcnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              shift  <= {1'b0, shift[7:1]};
              tx     <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            state <= IDLE;
            baud  <= RELOAD;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/soc_mem_responder.sv
// Processor-side memory target: word RAM plus an IO page (LEDs, UART, status).
// Define SOC_CYCLE_COUNTER_EN to expose a free-running cycle counter at IO reg 3.
module soc_mem_responder
  import soc_mem_pkg::*;
#(
  parameter int RAM_WORDS   = 1536,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [4:0]  leds,
  output logic        uart_tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    ram [RAM_WORDS];
  logic [19:0]    word_idx;
  logic [AW-1:0]  ram_addr;
  logic [2:0]     io_reg;
  logic           is_io, ram_hit, uart_push;
  logic           tx_busy, tx_full;
  logic [CW-1:0]  tx_count;
  logic [31:0]    io_rd, rd_next;
  logic           unused_bits;

  assign is_io     = mem_addr[IO_PAGE_BIT];
  assign word_idx  = mem_addr[21:2];
  assign ram_addr  = word_idx[AW-1:0];
  assign io_reg    = mem_addr[4:2];
  // Out-of-range words must not alias onto low RAM, so compare the full index.
  assign ram_hit   = !is_io && ({12'd0, word_idx} < RAM_WORDS);
  assign uart_push = is_io && (io_reg == REG_UART_DATA) && mem_wmask[0];
  assign unused_bits = ^{mem_addr[31:23], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (ram_hit) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[ram_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

`ifdef SOC_CYCLE_COUNTER_EN
  logic [31:0] cycles;
  always_ff @(posedge clk) begin
    if (!resetn) cycles <= '0;
    else         cycles <= cycles + 32'd1;
  end
`endif

  always_comb begin
    io_rd = '0;
    case (io_reg)
      REG_LEDS:        io_rd = {27'd0, leds};
      REG_UART_STATUS: io_rd = uart_status(tx_busy, tx_full, 4'(tx_count));
`ifdef SOC_CYCLE_COUNTER_EN
      REG_CYCLES:      io_rd = cycles;
`endif
      default:         io_rd = '0;
    endcase
  end

  always_comb begin
    rd_next = '0;
    if (is_io)        rd_next = io_rd;
    else if (ram_hit) rd_next = ram[ram_addr];
  end

  // Registered read naturally returns pre-write data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (!resetn)        mem_rdata <= '0;
    else if (mem_rstrb) mem_rdata <= rd_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      leds <= '0;
    else if (is_io && (io_reg == REG_LEDS) && mem_wmask[0])
      leds <= mem_wdata[4:0];
  end

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV        (DIV)
  ) u_uart (
    .clk       (clk),
    .resetn    (resetn),
    .push      (uart_push),
    .push_data (mem_wdata[7:0]),
    .tx        (uart_tx),
    .busy      (tx_busy),
    .full      (tx_full),
    .count     (tx_count)
  );

endmodule

// File: tb/tb_soc_mem_responder.sv
// Directed bench for soc_mem_responder: read scoreboard plus a UART frame decoder.
module tb_soc_mem_responder;

  localparam int DIV = 4;
  localparam logic [31:0] IO      = 32'h0040_0000;
  localparam logic [31:0] IO_UART = 32'h0040_0004;
  localparam logic [31:0] IO_STAT = 32'h0040_0008;
  localparam logic [31:0] IO_CYC  = 32'h0040_000C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_rstrb = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_rdata;
  logic [4:0]  leds;
  logic        uart_tx;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_q[$];
  bit          mon_en = 1'b0;
  logic [7:0]  mon_byte;
  logic [9:0]  fb;
  logic        saw_low;
  logic [31:0] c0, c1;

  always #5 clk = ~clk;

  soc_mem_responder #(
    .RAM_WORDS   (1536),
    .CLK_FREQ_HZ (400),
    .BAUD        (100),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .leds      (leds),
    .uart_tx   (uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Inputs change on negedges; each access occupies exactly one cycle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    @(negedge clk);
    mem_wmask = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    mem_addr = a; mem_rstrb = 1'b1;
    rd_q.push_back(exp_v);
    @(negedge clk);
    mem_rstrb = 1'b0;
    check(tag, mem_rdata, rd_q.pop_front());
  endtask

  task automatic rd_raw(input logic [31:0] a, output logic [31:0] v);
    mem_addr = a; mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
    v = mem_rdata;
  endtask

  // Frame decoder: start edge seen at bit-slot cycle 0, data sampled mid-slot.
  initial forever begin
    @(negedge clk);
    if (mon_en && uart_tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        mon_byte[i] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      rx_q.push_back(mon_byte);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_leds", {27'd0, leds}, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // RAM word, byte merge, read-before-write, hold
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd("ram_word", 32'h10, 32'hDEADBEEF);
    wr(32'h10, 32'h00AA0000, 4'b0100);
    rd("byte_merge", 32'h10, 32'hDEAABEEF);
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    mem_addr = 32'h10; mem_wdata = 32'h12345678; mem_wmask = 4'hF; mem_rstrb = 1'b1;
    rd_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    mem_wmask = '0; mem_rstrb = 1'b0;
    check("rbw_old", mem_rdata, rd_q.pop_front());
    rd("rbw_new", 32'h13, 32'h12345678);
    @(negedge clk);
    check("rdata_hold", mem_rdata, 32'h12345678);

    // Range boundary and no wrap
    wr(32'h0, 32'h0BADC0DE, 4'hF);
    wr(32'h17FC, 32'hCAFEF00D, 4'hF);
    rd("ram_last", 32'h17FC, 32'hCAFEF00D);
    wr(32'h1800, 32'h11111111, 4'hF);
    rd("ram_oor", 32'h1800, 32'd0);
    rd("ram_nowrap", 32'h0, 32'h0BADC0DE);

    // IO page
    wr(IO, 32'h0000001F, 4'b0001);
    check("leds", {27'd0, leds}, 32'h1F);
    rd("leds_rd", IO, 32'h1F);
    wr(IO, 32'h00000003, 4'b1110);
    check("leds_mask", {27'd0, leds}, 32'h1F);
    wr(IO_STAT, 32'hFFFFFFFF, 4'hF);
    rd("status_ro", IO_STAT, 32'd0);
    rd("uart_data_rd", IO_UART, 32'd0);
    rd("io_hole", IO | 32'h14, 32'd0);

    // Single frame 0xA5: sample each slot at its second cycle
    fb = {1'b1, 8'hA5, 1'b0};
    wr(IO_UART, 32'h000000A5, 4'b0001);
    repeat (2) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      check($sformatf("frame_bit%0d", b), {31'd0, uart_tx}, {31'd0, fb[b]});
      if (b == 4) begin
        rd("busy_mid", IO_STAT, 32'h1);
        repeat (DIV - 1) @(negedge clk);
      end else if (b < 9) begin
        repeat (DIV) @(negedge clk);
      end
    end
    repeat (DIV - 2) @(negedge clk);
    rd("busy_stop", IO_STAT, 32'h1);
    rd("idle_after_stop", IO_STAT, 32'h0);

    // FIFO overflow: 6 back-to-back pushes, 5 accepted
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr(IO_UART, 32'h30 + i, 4'b0001);
      if (i < 5) tx_exp.push_back(8'(8'h30 + i));
    end
    rd("fifo_full_status", IO_STAT, 32'h43);
    for (int t = 0; t < 6 * (10 * DIV + 1) + 20 && rx_q.size() < 5; t++) @(negedge clk);
    repeat (12 * DIV) @(negedge clk);
    check("frame_count", rx_q.size(), 32'd5);
    while (rx_q.size() > 0 && tx_exp.size() > 0)
      check("rx_byte", {24'd0, rx_q.pop_front()}, {24'd0, tx_exp.pop_front()});
    rd("idle_final", IO_STAT, 32'd0);
    mon_en = 1'b0;

    // Reset during DATA with bytes still queued
    for (int i = 0; i < 3; i++) wr(IO_UART, 32'h5A, 4'b0001);
    repeat (12) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_mid_leds", {27'd0, leds}, 32'd0);
    resetn = 1'b1;
    rd("rst_mid_status", IO_STAT, 32'd0);
    saw_low = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("rst_fifo_discard", {31'd0, saw_low}, 32'd0);

`ifdef SOC_CYCLE_COUNTER_EN
    rd_raw(IO_CYC, c0);
    repeat (9) @(negedge clk);
    rd_raw(IO_CYC, c1);
    check("cycles_delta", c1 - c0, 32'd10);
`else
    c0 = '0; c1 = '0;
    rd("cycles_off", IO_CYC, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
